// File: rtl/register_file_forwarder_if.sv
// Operand/result bus between the pipeline control, the ALU operand path and register_file_forwarder.
interface register_file_forwarder_if #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
);
  localparam int IDX_W = $clog2(REG_COUNT);

  logic             stall;
  logic             flush;
  logic             ex_write_enable;
  logic             ex_is_load;
  logic [IDX_W-1:0] ex_write_index;
  logic [XLEN-1:0]  ex_result;
  logic [XLEN-1:0]  mem_load_data;
  logic [IDX_W-1:0] read_index_1;
  logic [IDX_W-1:0] read_index_2;
  logic [XLEN-1:0]  bus_rs1;
  logic [XLEN-1:0]  bus_rs2;
  logic [XLEN-1:0]  Forward_rs1;
  logic [XLEN-1:0]  Forward_rs2;
  logic [1:0]       forward_select_1;
  logic [1:0]       forward_select_2;
  logic             load_hazard;

  modport master (
    output stall, flush, ex_write_enable, ex_is_load, ex_write_index, ex_result,
           mem_load_data, read_index_1, read_index_2,
    input  bus_rs1, bus_rs2, Forward_rs1, Forward_rs2,
           forward_select_1, forward_select_2, load_hazard
  );

  modport slave (
    input  stall, flush, ex_write_enable, ex_is_load, ex_write_index, ex_result,
           mem_load_data, read_index_1, read_index_2,
    output bus_rs1, bus_rs2, Forward_rs1, Forward_rs2,
           forward_select_1, forward_select_2, load_hazard
  );
endinterface

// File: rtl/register_file_forwarder.sv
// Integer register file with EX/MEM/WB result tracking, operand forwarding and load-use hazard detect.
// Define FORWARDING_EN for bypassing; otherwise selects stay 00 and hazards interlock until WB.
module register_file_forwarder #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  register_file_forwarder_if.slave  rf
);
  localparam int IDX_W = $clog2(REG_COUNT);

  typedef struct packed {
    logic             valid;
    logic             is_load;
    logic [IDX_W-1:0] index;
    logic [XLEN-1:0]  data;
  } slot_t;

  typedef enum logic [1:0] {
    SRC_REGFILE = 2'b00,
    SRC_EX      = 2'b01,
    SRC_MEM     = 2'b10,
    SRC_WB      = 2'b11
  } src_t;

  slot_t           ex_slot;
  slot_t           mem_q;
  slot_t           wb_q;
  logic [XLEN-1:0] mem_data;
  logic            wb_write;
  logic [XLEN-1:0] regs [REG_COUNT];

  always_comb begin
    ex_slot.valid   = rf.ex_write_enable & ~rf.flush;
    ex_slot.is_load = rf.ex_is_load;
    ex_slot.index   = rf.ex_write_index;
    ex_slot.data    = rf.ex_result;
  end

  assign mem_data = mem_q.is_load ? rf.mem_load_data : mem_q.data;
  assign wb_write = wb_q.valid && (wb_q.index != '0);

  // WB commits even under stall; the slot is then replaced by a bubble so it commits only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      wb_q  <= '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (wb_write) regs[wb_q.index] <= wb_q.data;
      if (rf.stall) begin
        wb_q <= '0;
      end else begin
        mem_q <= ex_slot;
        wb_q  <= '{valid: mem_q.valid, is_load: mem_q.is_load, index: mem_q.index, data: mem_data};
      end
    end
  end

  function automatic logic slot_hit(slot_t s, logic [IDX_W-1:0] idx);
    return s.valid && (idx != '0) && (s.index == idx);
  endfunction

  function automatic logic [XLEN-1:0] rf_read(logic [IDX_W-1:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (idx != '0) val = (wb_write && (wb_q.index == idx)) ? wb_q.data : regs[idx];
    return val;
  endfunction

  logic [XLEN-1:0] bus_1;
  logic [XLEN-1:0] bus_2;

  assign bus_1      = rf_read(rf.read_index_1);
  assign bus_2      = rf_read(rf.read_index_2);
  assign rf.bus_rs1 = bus_1;
  assign rf.bus_rs2 = bus_2;

`ifdef FORWARDING_EN
  src_t            sel_1;
  src_t            sel_2;
  logic [XLEN-1:0] fwd_1;
  logic [XLEN-1:0] fwd_2;

  // Youngest producer wins: EX, then MEM, then WB, then the architectural value.
  always_comb begin
    sel_1 = SRC_REGFILE;
    fwd_1 = bus_1;
    if (slot_hit(ex_slot, rf.read_index_1)) begin
      sel_1 = SRC_EX;
      fwd_1 = ex_slot.data;
    end else if (slot_hit(mem_q, rf.read_index_1)) begin
      sel_1 = SRC_MEM;
      fwd_1 = mem_data;
    end else if (slot_hit(wb_q, rf.read_index_1)) begin
      sel_1 = SRC_WB;
      fwd_1 = wb_q.data;
    end
  end

  always_comb begin
    sel_2 = SRC_REGFILE;
    fwd_2 = bus_2;
    if (slot_hit(ex_slot, rf.read_index_2)) begin
      sel_2 = SRC_EX;
      fwd_2 = ex_slot.data;
    end else if (slot_hit(mem_q, rf.read_index_2)) begin
      sel_2 = SRC_MEM;
      fwd_2 = mem_data;
    end else if (slot_hit(wb_q, rf.read_index_2)) begin
      sel_2 = SRC_WB;
      fwd_2 = wb_q.data;
    end
  end

  assign rf.forward_select_1 = sel_1;
  assign rf.forward_select_2 = sel_2;
  assign rf.Forward_rs1      = fwd_1;
  assign rf.Forward_rs2      = fwd_2;
  assign rf.load_hazard      = ex_slot.is_load &&
                               (slot_hit(ex_slot, rf.read_index_1) || slot_hit(ex_slot, rf.read_index_2));
`else
  assign rf.forward_select_1 = SRC_REGFILE;
  assign rf.forward_select_2 = SRC_REGFILE;
  assign rf.Forward_rs1      = bus_1;
  assign rf.Forward_rs2      = bus_2;
  // Without bypass a reader waits until the producer reaches WB, where write-through covers it.
  assign rf.load_hazard      = slot_hit(ex_slot, rf.read_index_1) || slot_hit(ex_slot, rf.read_index_2) ||
                               slot_hit(mem_q, rf.read_index_1)   || slot_hit(mem_q, rf.read_index_2);
`endif

endmodule
